// File: rtl/ctrl_uart_tx.sv
// ctrl_uart_tx -- buffered 8N1 UART transmitter for the ctrlsoc serial console.
//
// Bytes written by firmware are queued in a small FIFO. A bit-timer FSM sends
// each byte as one start bit (0), eight data bits LSB-first and one stop bit (1).
// Every bit lasts CLK_DIV clock cycles. When the FIFO still holds data at the
// end of a stop bit, the next start bit follows at once, with no idle gap.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset; aborts any frame in flight
//                   and discards every queued byte
//   wr_valid   in   a byte is offered on wr_data
//   wr_data    in   byte to transmit
//   wr_ready   out  the FIFO has room (fifo_level != FIFO_DEPTH)
//   ser_tx     out  serial line; idles high and is driven straight from a flop
//   busy       out  a frame is in progress or the FIFO is not empty
//   fifo_level out  number of queued bytes, 0..FIFO_DEPTH
//
// Handshake: a byte is taken on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on fifo_level, never on wr_valid. When the FIFO is full,
// a write is refused even if a byte is popped on that same edge.
module ctrl_uart_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  output logic               ser_tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0]      TIMER_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LEVEL_FULL   = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_t               state;
  state_t               state_nxt;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [15:0]          timer;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;

  logic                 push;
  logic                 fifo_empty;
  logic                 timer_done;

  // Control strobes produced by the FSM output decoder
  logic                 pop;
  logic                 load_timer;
  logic                 shift_en;
  logic                 clr_idx;
  logic                 tx_load;
  logic                 tx_next;

  assign fifo_empty = (fifo_level == '0);
  assign wr_ready   = (fifo_level != LEVEL_FULL);
  assign push       = wr_valid && wr_ready;
  assign timer_done = (timer == '0);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_START;
      S_START: if (timer_done)  state_nxt = S_DATA;
      S_DATA:  if (timer_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (timer_done)  state_nxt = fifo_empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (datapath strobes) ----------------
  always_comb begin
    pop        = 1'b0;
    load_timer = 1'b0;
    shift_en   = 1'b0;
    clr_idx    = 1'b0;
    tx_load    = 1'b0;
    tx_next    = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load_timer = 1'b1;
          tx_load    = 1'b1;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (timer_done) begin
          clr_idx    = 1'b1;
          load_timer = 1'b1;
          tx_load    = 1'b1;
          tx_next    = shift[0];
        end
      end
      S_DATA: begin
        if (timer_done) begin
          load_timer = 1'b1;
          tx_load    = 1'b1;
          if (bit_idx == 3'd7) begin
            tx_next = 1'b1;
          end else begin
            // The next bit is shift[1], because shift moves right on this same edge.
            shift_en = 1'b1;
            tx_next  = shift[1];
          end
        end
      end
      S_STOP: begin
        if (timer_done) begin
          tx_load = 1'b1;
          if (!fifo_empty) begin
            // Start the next frame at once so frames stay back to back.
            pop        = 1'b1;
            load_timer = 1'b1;
            tx_next    = 1'b0;
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_tx     <= 1'b1;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (tx_load) ser_tx <= tx_next;

      // The timer stays at 0 in IDLE and counts down in every other state.
      if (load_timer)                          timer <= TIMER_RELOAD;
      else if (!timer_done && state != S_IDLE) timer <= timer - 16'd1;

      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end else if (shift_en) begin
        shift  <= {1'b0, shift[7:1]};
      end

      if (clr_idx)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The storage array has no reset; the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_ctrl_uart_tx.sv
// tb_ctrl_uart_tx -- testbench for ctrl_uart_tx.
// Lane 0 runs a DUT with CLK_DIV=104 through directed traffic. Lane 1 runs a
// DUT with CLK_DIV=2 through randomised traffic. Each lane has a reference
// model built from a byte queue and a count of cycles left in the current
// frame. It also has a serial receiver that decodes ser_tx and compares each
// decoded byte with the expected queue.
module tb_ctrl_uart_tx;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid_r [2];
  logic [7:0] wr_data_r  [2];
  logic       wr_ready_w [2];
  logic       ser_tx_w   [2];
  logic       busy_w     [2];
  logic [4:0] level_w    [2];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- lanes: DUT + reference model + receiver ----------------
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int C     = (g == 0) ? 104 : 2;
    localparam int FRAME = 10 * C;

    logic [7:0] exp_q [$];   // bytes accepted and not yet decoded
    logic [7:0] m_q   [$];   // model FIFO contents
    logic [7:0] rx_log [$];  // every decoded byte, in order
    logic [7:0] m_cur;
    int         m_rem;
    int         rx_cnt;

    ctrl_uart_tx #(.CLK_DIV(C), .FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid_r[g]),
      .wr_data    (wr_data_r[g]),
      .wr_ready   (wr_ready_w[g]),
      .ser_tx     (ser_tx_w[g]),
      .busy       (busy_w[g]),
      .fifo_level (level_w[g])
    );

    // The model works at frame level. A pop starts a frame of FRAME cycles.
    // The bit on the line comes from how many cycles of that frame have passed.
    initial begin : model
      logic acc;
      int   el;
      int   b;
      logic exp_tx;
      m_rem = 0;
      m_cur = '0;
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
          m_q.delete();
          exp_q.delete();
          m_rem = 0;
        end else begin
          acc = wr_valid_r[g] && (m_q.size() != DEPTH);
          if (m_rem > 0) m_rem--;
          if (m_rem == 0 && m_q.size() != 0) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
          end
          if (acc) begin
            m_q.push_back(wr_data_r[g]);
            exp_q.push_back(wr_data_r[g]);
          end
        end
        #1;
        if (m_rem == 0) begin
          exp_tx = 1'b1;
        end else begin
          el = FRAME - m_rem;
          b  = el / C;
          if (b == 0)      exp_tx = 1'b0;
          else if (b == 9) exp_tx = 1'b1;
          else             exp_tx = m_cur[b-1];
        end
        check_eq($sformatf("L%0d ser_tx", g), ser_tx_w[g], exp_tx);
        check_eq($sformatf("L%0d busy", g), busy_w[g], (m_rem != 0) || (m_q.size() != 0));
        check_eq($sformatf("L%0d fifo_level", g), level_w[g], m_q.size());
        check_eq($sformatf("L%0d wr_ready", g), wr_ready_w[g], m_q.size() != DEPTH);
      end
    end

    // Receiver: finds the falling edge of the start bit, samples the first data
    // bit 1.5 bit periods later, samples each further bit one period apart,
    // then checks the stop bit.
    initial begin : receiver
      logic       rx_busy;
      int         rx_t;
      logic [7:0] rx_byte;
      int         off;
      rx_busy = 1'b0;
      rx_t    = 0;
      rx_cnt  = 0;
      rx_byte = '0;
      forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
          rx_busy = 1'b0;
          rx_t    = 0;
        end else if (!rx_busy) begin
          if (!ser_tx_w[g]) begin
            rx_busy = 1'b1;
            rx_t    = 0;
            rx_byte = '0;
          end
        end else begin
          rx_t++;
          off = rx_t - C - C / 2;
          if (rx_t < 9 * C && off >= 0 && (off % C) == 0) begin
            rx_byte[3'(off / C)] = ser_tx_w[g];
          end else if (rx_t == 9 * C + C / 2) begin
            check_eq($sformatf("L%0d stop_bit", g), ser_tx_w[g], 1);
            check_eq($sformatf("L%0d rx_expected", g), exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq($sformatf("L%0d rx_byte", g), rx_byte, exp_q.pop_front());
            rx_log.push_back(rx_byte);
            rx_cnt++;
            rx_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offers byte b and waits until the byte is accepted. wr_valid stays high when
  // the task returns, so consecutive calls write on consecutive cycles.
  task automatic send(input int ln, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid_r[ln] = 1'b1;
    wr_data_r[ln]  = b;
    while (!wr_ready_w[ln] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("L%0d send_accept", ln), n < 5000, 1);
  endtask

  task automatic release_wr(input int ln);
    @(negedge clk);
    wr_valid_r[ln] = 1'b0;
  endtask

  task automatic wait_idle(input int ln, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_w[ln] && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("L%0d idle_reached", ln), busy_w[ln], 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    reset = 1'b1;
    for (int l = 0; l < 2; l++) begin
      wr_valid_r[l] = 1'b0;
      wr_data_r[l]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("L%0d rst ser_tx", l), ser_tx_w[l], 1);
      check_eq($sformatf("L%0d rst busy", l), busy_w[l], 0);
      check_eq($sformatf("L%0d rst level", l), level_w[l], 0);
      check_eq($sformatf("L%0d rst wr_ready", l), wr_ready_w[l], 1);
    end
    reset = 1'b0;

    // Single byte
    send(0, 8'h55);
    release_wr(0);
    wait_idle(0, 2000);

    // Three consecutive bytes -> contiguous frames
    send(0, 8'h48);
    send(0, 8'h69);
    send(0, 8'h0A);
    release_wr(0);
    wait_idle(0, 4000);

    // Hold wr_valid for 18 cycles: 17 accepted, FIFO full
    @(negedge clk);
    wr_valid_r[0] = 1'b1;
    wr_data_r[0]  = 8'($urandom_range(0, 255));
    for (int i = 1; i < 18; i++) begin
      @(negedge clk);
      wr_data_r[0] = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    check_eq("L0 full level", level_w[0], 16);
    check_eq("L0 full wr_ready", wr_ready_w[0], 0);
    wr_valid_r[0] = 1'b0;
    repeat (1000) @(negedge clk);
    check_eq("L0 still full", level_w[0], 16);
    wait_idle(0, 20000);

    // Reset about 494 cycles into a frame with 5 bytes queued
    for (int i = 0; i < 6; i++) send(0, 8'(i * 17));
    release_wr(0);
    repeat (490) @(negedge clk);
    check_eq("L0 mid-frame ser_tx", ser_tx_w[0], 0);
    check_eq("L0 mid-frame level", level_w[0], 5);
    reset = 1'b1;
    #1;
    check_eq("L0 abort ser_tx", ser_tx_w[0], 1);
    check_eq("L0 abort level", level_w[0], 0);
    check_eq("L0 abort busy", busy_w[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(0, 8'hA5);
    release_wr(0);
    wait_idle(0, 2000);

    // All-zero and all-one bytes
    send(0, 8'h00);
    send(0, 8'hFF);
    release_wr(0);
    wait_idle(0, 3000);

    // Random bytes with random gaps, CLK_DIV=2
    for (int i = 0; i < 200; i++) begin
      send(1, 8'($urandom_range(0, 255)));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      if (gap != 0) begin
        release_wr(1);
        repeat (gap - 1) @(negedge clk);
      end
    end
    release_wr(1);
    wait_idle(1, 10000);
    repeat (5) @(negedge clk);

    // End-of-run scoreboard
    check_eq("L0 rx_count", lane[0].rx_cnt, 24);
    check_eq("L0 exp_q drained", lane[0].exp_q.size(), 0);
    check_eq("L1 rx_count", lane[1].rx_cnt, 200);
    check_eq("L1 exp_q drained", lane[1].exp_q.size(), 0);
    if (lane[0].rx_log.size() == 24) begin
      check_eq("L0 text U", lane[0].rx_log[0], 8'h55);
      check_eq("L0 text H", lane[0].rx_log[1], 8'h48);
      check_eq("L0 text i", lane[0].rx_log[2], 8'h69);
      check_eq("L0 text nl", lane[0].rx_log[3], 8'h0A);
      check_eq("L0 after reset", lane[0].rx_log[21], 8'hA5);
      check_eq("L0 zero byte", lane[0].rx_log[22], 8'h00);
      check_eq("L0 ones byte", lane[0].rx_log[23], 8'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
